vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive denied CPU cycles before a forced CPU grant (range 1..255).
REQ-002 clk  input  1  system clock (all logic on posedge clk).
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 blank  input  1  high during video blanking.
REQ-005 pix_req  input  1  pixel-fetch read request for this cycle.
REQ-006 pix_addr  input  13  pixel-fetch VRAM address.
REQ-007 pix_gnt  output  1  pix_req accepted this cycle.
REQ-008 pix_rvalid  output  1  pix_rdata valid, two cycles after pix_gnt.
REQ-009 pix_rdata  output  8  pixel-fetch read data.
REQ-010 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-011 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-012 cpu_addr  input  13  CPU VRAM address; stable while cpu_req is high.
REQ-013 cpu_wdata  input  8  CPU write data; stable while cpu_req is high.
REQ-014 cpu_ack  output  1  one-cycle completion pulse.
REQ-015 cpu_rdata  output  8  read data, valid with cpu_ack when cpu_we = 0.
REQ-016 mem_addr  output  13  registered VRAM address.
REQ-017 mem_we  output  1  registered VRAM write strobe.
REQ-018 mem_wdata  output  8  registered VRAM write data.
REQ-019 mem_rdata  input  8  VRAM read data, one cycle after mem_addr (synchronous RAM).

Function
REQ-020 One grant per cycle is evaluated at posedge clk: the grant is PIX, CPU or NONE.
REQ-021 A granted request drives mem_* in cycle N+1; the response (pix_rvalid or cpu_ack) appears in cycle N+2.
- Fully pipelined: a grant can be issued every cycle.
REQ-022 Priority order, highest first:
- (a) CPU if blank = 1 and a CPU request is pending.
- (b) CPU if the starvation count is at least STARVE_LIMIT.
- (c) PIX if pix_req = 1.
- (d) CPU if a CPU request is pending.
- (e) NONE.
REQ-023 "CPU pending" = cpu_req high and no CPU transaction in flight (the busy flag is clear).
- Busy is set on the CPU grant and cleared in the cpu_ack cycle.
REQ-024 A CPU request still high in the cycle after cpu_ack is a new transaction and is eligible for grant.
REQ-025 pix_gnt is combinational from the current-cycle arbitration.
- When pix_req = 1 and pix_gnt = 0, the requester holds pix_addr and re-presents it.
REQ-026 A NONE grant drives mem_we = 0 and holds mem_addr at its previous value.
REQ-027 mem_we = 1 only in the cycle following a CPU write grant.
- A CPU write still produces cpu_ack in cycle N+2; cpu_rdata is don't-care for writes.
REQ-028 Starvation counter, 8 bits:
- Increments each cycle CPU is pending and not granted.
- Clears on a CPU grant, or when no CPU request is pending.
- Saturates at 255.
REQ-029 Simultaneous pix_req and CPU pending with the counter at STARVE_LIMIT: CPU is granted, pix_gnt = 0, and the counter clears.
REQ-030 pix_rdata and cpu_rdata are registered copies of mem_rdata, updated only in their own valid cycle.
- Each holds its value otherwise.

Reset
REQ-031 While rst = 0, all outputs are 0, busy is 0, the counter is 0 and the in-flight pipeline is cleared.
REQ-032 Reset during a transaction drops it: no pix_rvalid and no cpu_ack are issued for it after release.
REQ-033 The first grant occurs on the first posedge clk with rst = 1.

Configuration
REQ-034 Macro VRAM_ARB_STARVE_EN selects the starvation counter.
- Defined: the counter and rule REQ-022(b) are present.
- Undefined: no counter exists, rule (b) is removed, strict priority applies, and STARVE_LIMIT is ignored.

Structure
REQ-035 Shared package gpu_pkg holds:
- VRAM_ADDR_W = 13 and VRAM_DATA_W = 8.
- Grant enum {GNT_NONE, GNT_PIX, GNT_CPU}.
REQ-036 One sub-module, vram_arb_starve_ctr, holds the saturating counter; it is instantiated only under VRAM_ARB_STARVE_EN.

Verification
REQ-037 Priority and latency: blank = 0, pix_req = 1 every cycle at pix_addr 0x0005, cpu_req = 0.
- Required: pix_gnt = 1 every cycle.
- Required: mem_addr = 0x0005 one cycle later; pix_rvalid with mem_rdata two cycles later.
REQ-038 Idle-slot CPU write: pix_req = 0, CPU write of 0xA5 to 0x1803.
- Required: mem_we = 1 with mem_addr 0x1803 and mem_wdata 0xA5 in cycle N+1.
- Required: a single cpu_ack in cycle N+2.
REQ-039 Starvation (macro defined, STARVE_LIMIT = 8): pix_req held high, CPU read of 0x0100.
- Required: pix_gnt = 0 in exactly the 9th cycle of the request, with the CPU granted in that cycle.
- Required: cpu_ack two cycles later; pix_gnt = 1 resumes the next cycle.
REQ-040 Starvation removed (macro undefined): same stimulus as REQ-039.
- Required: no cpu_ack while pix_req = 1.
- Required: the CPU is granted in the first cycle pix_req = 0.
REQ-041 Blanking: blank = 1 with pix_req and cpu_req both high.
- Required: CPU granted immediately and pix_gnt = 0.
- Required: a back-to-back second CPU request is granted the cycle after cpu_ack.
REQ-042 Reset mid-operation: assert rst = 0 one cycle after a CPU read grant, release two cycles later.
- Required: no cpu_ack is seen.
- Required: all outputs are 0 during reset.
- Required: the held cpu_req is re-granted on the first cycle after release.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM geometry and the arbiter grant encoding.
package gpu_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIX  = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

endpackage

// File: rtl/vram_arb_starve_ctr.sv
// Saturating 8-bit count of consecutive cycles the CPU waited while pending.
// Only instantiated when VRAM_ARB_STARVE_EN is defined.
module vram_arb_starve_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       starving,
  output logic [7:0] count
);

  // Count up while the CPU is pending and not granted, otherwise restart at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (!starving) begin
      count <= 8'd0;
    end else if (count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter between the pixel-fetch stream and the CPU port.
// One grant per cycle; mem_* is driven the cycle after the grant and the
// response (pix_rvalid / cpu_ack) follows one cycle later, fully pipelined.
// Define VRAM_ARB_STARVE_EN to add the CPU starvation counter and the forced
// CPU grant once the CPU has waited STARVE_LIMIT cycles; without it the
// arbiter uses strict priority and STARVE_LIMIT has no effect.
module vram_arbiter
  import gpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blank,
  input  logic                   pix_req,
  input  logic [VRAM_ADDR_W-1:0] pix_addr,
  output logic                   pix_gnt,
  output logic                   pix_rvalid,
  output logic [VRAM_DATA_W-1:0] pix_rdata,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [VRAM_ADDR_W-1:0] cpu_addr,
  input  logic [VRAM_DATA_W-1:0] cpu_wdata,
  output logic                   cpu_ack,
  output logic [VRAM_DATA_W-1:0] cpu_rdata,
  output logic [VRAM_ADDR_W-1:0] mem_addr,
  output logic                   mem_we,
  output logic [VRAM_DATA_W-1:0] mem_wdata,
  input  logic [VRAM_DATA_W-1:0] mem_rdata
);

  gnt_e                   gnt;
  gnt_e                   s1_gnt;
  logic                   s2_we;
  logic                   busy;
  logic                   cpu_pending;
  logic                   starve_hit;
  logic [VRAM_DATA_W-1:0] pix_hold;
  logic [VRAM_DATA_W-1:0] cpu_hold;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("vram_arbiter: STARVE_LIMIT must lie in 1..255");
  end

  // A CPU request only competes when no CPU transaction is already in flight.
  assign cpu_pending = cpu_req && !busy;

`ifdef VRAM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_THRESH = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;

  vram_arb_starve_ctr u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .starving (cpu_pending && (gnt != GNT_CPU)),
    .count    (starve_cnt)
  );

  assign starve_hit = cpu_pending && (starve_cnt >= STARVE_THRESH);
`else
  assign starve_hit = 1'b0;
`endif

  // Priority: CPU in blanking, starved CPU, pixel fetch, then idle-slot CPU.
  always_comb begin
    gnt = GNT_NONE;
    if (blank && cpu_pending) begin
      gnt = GNT_CPU;
    end else if (starve_hit) begin
      gnt = GNT_CPU;
    end else if (pix_req) begin
      gnt = GNT_PIX;
    end else if (cpu_pending) begin
      gnt = GNT_CPU;
    end
  end

  // pix_gnt must read low while reset is asserted, even with pix_req high.
  assign pix_gnt = rst && (gnt == GNT_PIX);

  // Memory stage: register the winner's address/data; idle slots keep the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_gnt    <= GNT_NONE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      s1_gnt <= gnt;
      mem_we <= (gnt == GNT_CPU) && cpu_we;
      case (gnt)
        GNT_PIX: mem_addr <= pix_addr;
        GNT_CPU: begin
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
        end
        default: ;
      endcase
    end
  end

  // Response stage: the synchronous RAM answers one cycle after mem_addr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_rvalid <= 1'b0;
      cpu_ack    <= 1'b0;
      s2_we      <= 1'b0;
    end else begin
      pix_rvalid <= (s1_gnt == GNT_PIX);
      cpu_ack    <= (s1_gnt == GNT_CPU);
      s2_we      <= mem_we;
    end
  end

  // Busy covers a CPU transaction from its grant until the end of its ack cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else if (gnt == GNT_CPU) begin
      busy <= 1'b1;
    end else if (cpu_ack) begin
      busy <= 1'b0;
    end
  end

  // Keep the last delivered read data so each rdata holds between its valid cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_hold <= '0;
      cpu_hold <= '0;
    end else begin
      if (pix_rvalid) begin
        pix_hold <= mem_rdata;
      end
      if (cpu_ack && !s2_we) begin
        cpu_hold <= mem_rdata;
      end
    end
  end

  assign pix_rdata = pix_rvalid ? mem_rdata : pix_hold;
  assign cpu_rdata = (cpu_ack && !s2_we) ? mem_rdata : cpu_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios with literal expectations plus
// a cycle-level reference model compared against the DUT on every cycle.
// Expectations adapt to VRAM_ARB_STARVE_EN.
module tb_vram_arbiter;
  import gpu_pkg::*;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blank = 1'b0;
  logic        pix_req = 1'b0;
  logic [12:0] pix_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  mem_rdata = '0;

  logic        pix_gnt;
  logic        pix_rvalid;
  logic [7:0]  pix_rdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .blank      (blank),
    .pix_req    (pix_req),
    .pix_addr   (pix_addr),
    .pix_gnt    (pix_gnt),
    .pix_rvalid (pix_rvalid),
    .pix_rdata  (pix_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Background VRAM contents: low address byte XOR the high address bits.
  function automatic logic [7:0] pattern(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  // Synchronous VRAM seen by the DUT: read-before-write, data one cycle after address.
  logic [7:0] ram_wr [int];
  always @(posedge clk) begin
    mem_rdata <= ram_wr.exists(int'(mem_addr)) ? ram_wr[int'(mem_addr)] : pattern(mem_addr);
    if (mem_we) ram_wr[int'(mem_addr)] = mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic pr, input logic [12:0] pa,
                               input logic cr, input logic cw, input logic [12:0] ca,
                               input logic [7:0] cd);
    blank     = b;
    pix_req   = pr;
    pix_addr  = pa;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    gnt_e        kind;
    logic [12:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  data;
  } txn_t;

  txn_t       slot1, slot2, nxt;
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [12:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] m_pix_hold = '0;
  logic [7:0] m_cpu_hold = '0;
  logic [7:0] m_mem [int];
  gnt_e       m_dec;
  logic       m_pending;

  initial begin
    slot1 = '0;
    slot2 = '0;
    nxt   = '0;
  end

  function automatic logic [7:0] modelRead(input logic [12:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : pattern(a);
  endfunction

  // Who should win this cycle, straight from the priority rules.
  function automatic gnt_e decide();
    logic pend;
    pend = cpu_req && !m_busy;
    if (blank && pend) return GNT_CPU;
`ifdef VRAM_ARB_STARVE_EN
    if (pend && m_cnt >= LIMIT) return GNT_CPU;
`endif
    if (pix_req) return GNT_PIX;
    if (pend) return GNT_CPU;
    return GNT_NONE;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot1 = '0;
      slot2 = '0;
      m_busy = 1'b0;
      m_cnt = 0;
      m_addr = '0;
      m_wdata = '0;
      m_pix_hold = '0;
      m_cpu_hold = '0;
    end else begin
      m_dec = decide();
      m_pending = cpu_req && !m_busy;
      if (slot2.kind == GNT_PIX) m_pix_hold = slot2.data;
      if (slot2.kind == GNT_CPU && !slot2.we) m_cpu_hold = slot2.data;
      if (slot2.kind == GNT_CPU) m_busy = 1'b0;
      nxt = slot1;
      nxt.data = modelRead(slot1.addr);
      if (slot1.kind == GNT_CPU && slot1.we) m_mem[int'(slot1.addr)] = slot1.wdata;
      slot2 = nxt;
      if (m_pending && m_dec != GNT_CPU) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else m_cnt = 0;
      if (m_dec == GNT_CPU) m_busy = 1'b1;
      slot1 = '0;
      slot1.kind = m_dec;
      if (m_dec == GNT_PIX) begin
        slot1.addr = pix_addr;
        m_addr = pix_addr;
      end else if (m_dec == GNT_CPU) begin
        slot1.addr  = cpu_addr;
        slot1.we    = cpu_we;
        slot1.wdata = cpu_wdata;
        m_addr  = cpu_addr;
        m_wdata = cpu_wdata;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    checkOutput("cmp_pix_gnt", 32'(pix_gnt), 32'(rst && decide() == GNT_PIX));
    checkOutput("cmp_pix_rvalid", 32'(pix_rvalid), 32'(slot2.kind == GNT_PIX));
    checkOutput("cmp_cpu_ack", 32'(cpu_ack), 32'(slot2.kind == GNT_CPU));
    checkOutput("cmp_mem_we", 32'(mem_we), 32'(slot1.kind == GNT_CPU && slot1.we));
    checkOutput("cmp_mem_addr", 32'(mem_addr), 32'(m_addr));
    if (slot1.kind == GNT_CPU && slot1.we)
      checkOutput("cmp_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    checkOutput("cmp_pix_rdata", 32'(pix_rdata),
                32'((slot2.kind == GNT_PIX) ? slot2.data : m_pix_hold));
    if (!(slot2.kind == GNT_CPU && slot2.we))
      checkOutput("cmp_cpu_rdata", 32'(cpu_rdata),
                  32'((slot2.kind == GNT_CPU) ? slot2.data : m_cpu_hold));
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_pix_gnt", 32'(pix_gnt), 32'd0);
    checkOutput("reset_cpu_ack", 32'(cpu_ack), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    nextCycle();
    rst = 1'b1;

    // Pixel stream alone: granted every cycle, address then data in the pipeline.
    applyStimulus(1'b0, 1'b1, 13'h0005, 1'b0, 1'b0, 13'h0, 8'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("stream_pix_gnt", 32'(pix_gnt), 32'd1);
      if (i >= 1) checkOutput("stream_mem_addr", 32'(mem_addr), 32'h0005);
      if (i >= 2) begin
        checkOutput("stream_pix_rvalid", 32'(pix_rvalid), 32'd1);
        checkOutput("stream_pix_rdata", 32'(pix_rdata), 32'h05);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 13'h0005, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (3) nextCycle();

    // CPU write in an idle slot, then read it back.
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b1, 1'b1, 13'h1803, 8'hA5);
    @(negedge clk);
    checkOutput("wr_grant_cycle_mem_we", 32'(mem_we), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
    checkOutput("wr_mem_addr", 32'(mem_addr), 32'h1803);
    checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    checkOutput("wr_early_ack", 32'(cpu_ack), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("wr_cpu_ack", 32'(cpu_ack), 32'd1);
    checkOutput("wr_mem_we_off", 32'(mem_we), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    @(negedge clk);
    checkOutput("wr_single_ack", 32'(cpu_ack), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b1, 1'b0, 13'h1803, 8'h0);
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("rd_back_ack", 32'(cpu_ack), 32'd1);
    checkOutput("rd_back_data", 32'(cpu_rdata), 32'hA5);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (2) nextCycle();

    // Pixel stream competing with a CPU read.
    applyStimulus(1'b0, 1'b1, 13'h0040, 1'b1, 1'b0, 13'h0100, 8'h0);
`ifdef VRAM_ARB_STARVE_EN
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 9) checkOutput("starve_forced_cpu", 32'(pix_gnt), 32'd0);
      else if (c <= 10) checkOutput("starve_pix_gnt", 32'(pix_gnt), 32'd1);
      checkOutput("starve_cpu_ack", 32'(cpu_ack), 32'(c == 11));
      if (c == 10) checkOutput("starve_mem_addr", 32'(mem_addr), 32'h0100);
      if (c == 11) checkOutput("starve_cpu_rdata", 32'(cpu_rdata), 32'h01);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 13'h0040, 1'b0, 1'b0, 13'h0, 8'h0);
    @(negedge clk);
    checkOutput("starve_pix_resume", 32'(pix_gnt), 32'd1);
    nextCycle();
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checkOutput("strict_pix_gnt", 32'(pix_gnt), 32'd1);
      checkOutput("strict_no_ack", 32'(cpu_ack), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 13'h0040, 1'b1, 1'b0, 13'h0100, 8'h0);
    @(negedge clk);
    checkOutput("strict_pix_gnt_off", 32'(pix_gnt), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("strict_mem_addr", 32'(mem_addr), 32'h0100);
    checkOutput("strict_mem_we", 32'(mem_we), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("strict_cpu_ack", 32'(cpu_ack), 32'd1);
    checkOutput("strict_cpu_rdata", 32'(cpu_rdata), 32'h01);
    nextCycle();
`endif
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (2) nextCycle();

    // Blanking: CPU wins at once, and a held request is regranted after its ack.
    applyStimulus(1'b1, 1'b1, 13'h0040, 1'b1, 1'b0, 13'h0200, 8'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checkOutput("blank_pix_gnt", 32'(pix_gnt), 32'((c == 1 || c == 4) ? 0 : 1));
      checkOutput("blank_cpu_ack", 32'(cpu_ack), 32'(c == 3 || c == 6));
      if (c == 3 || c == 6) checkOutput("blank_cpu_rdata", 32'(cpu_rdata), 32'h02);
      if (c == 2 || c == 5) checkOutput("blank_mem_addr", 32'(mem_addr), 32'h0200);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (2) nextCycle();

    // Reset in the middle of a CPU read.
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b1, 1'b0, 13'h0300, 8'h0);
    @(negedge clk);
    checkOutput("rstmid_grant_pix_gnt", 32'(pix_gnt), 32'd0);
    nextCycle();
    rst = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      checkOutput("rstmid_pix_gnt", 32'(pix_gnt), 32'd0);
      checkOutput("rstmid_pix_rvalid", 32'(pix_rvalid), 32'd0);
      checkOutput("rstmid_cpu_ack", 32'(cpu_ack), 32'd0);
      checkOutput("rstmid_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("rstmid_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rstmid_mem_wdata", 32'(mem_wdata), 32'd0);
      checkOutput("rstmid_pix_rdata", 32'(pix_rdata), 32'd0);
      checkOutput("rstmid_cpu_rdata", 32'(cpu_rdata), 32'd0);
      nextCycle();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_no_stale_ack", 32'(cpu_ack), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rstmid_regrant_addr", 32'(mem_addr), 32'h0300);
    checkOutput("rstmid_no_ack_yet", 32'(cpu_ack), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rstmid_cpu_ack", 32'(cpu_ack), 32'd1);
    checkOutput("rstmid_cpu_rdata", 32'(cpu_rdata), 32'h03);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (3) nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
